// File: rtl/pcpu_bus_pkg.sv
// rtl/pcpu_bus_pkg.sv - shared bus sequencer states, master indices and address region nibbles
package pcpu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } bus_state_e;

   localparam logic MST_M0 = 1'b0;
   localparam logic MST_M1 = 1'b1;

   // Top address nibble selects the bus region.
   localparam logic [3:0] REG_DISTM = 4'h1;
   localparam logic [3:0] REG_MAINM = 4'h2;
   localparam logic [3:0] REG_MMIO  = 4'h9;
   localparam logic [3:0] REG_BOOTM = 4'hf;

   function automatic logic [3:0] addr_region(input logic [31:0] addr);
      return addr[31:28];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way picker, round-robin or fixed m0 priority
module rr_arb2
   import pcpu_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       fixed_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         // Contention: m0 wins under fixed priority or when m1 owned the bus last.
         if (fixed_i || (last_i == MST_M1)) begin
            gnt_o = 2'b01;
         end else begin
            gnt_o = 2'b10;
         end
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/mbus_arbiter.sv
// rtl/mbus_arbiter.sv - two-master bus arbiter/sequencer with strobe issue, ready wait and timeout
module mbus_arbiter
   import pcpu_bus_pkg::*;
#(
   parameter int TIMEOUT    = 1024,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_a,
   input  logic [31:0] m0_d,
   output logic [31:0] m0_spo,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_a,
   input  logic [31:0] m1_d,
   output logic [31:0] m1_spo,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] a,
   output logic [31:0] d,
   output logic        we,
   output logic        rd,
   input  logic [31:0] spo,
   input  logic        ready,
   input  logic        irq,
   output logic [1:0]  grant
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   bus_state_e    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   d_q, d_d;
   logic          we_q, we_d;
   logic          rd_q, rd_d;
   logic [1:0]    grant_q, grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   m0_spo_q, m0_spo_d, m1_spo_q, m1_spo_d;
   logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;

   logic [1:0]    gnt;
   logic          fin;
   logic [31:0]   fin_spo;
   logic          fin_err;
   logic          pick_we;

   rr_arb2 u_arb (
      .req_i   ({m1_req, m0_req}),
      .last_i  (last_q),
      .fixed_i (FIXED_PRIO),
      .gnt_o   (gnt)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      a_d      = a_q;
      d_d      = d_q;
      we_d     = 1'b0;
      rd_d     = 1'b0;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      m0_spo_d = m0_spo_q;
      m1_spo_d = m1_spo_q;
      m0_err_d = m0_err_q;
      m1_err_d = m1_err_q;
      fin      = 1'b0;
      fin_spo  = 32'h0;
      fin_err  = 1'b0;
      pick_we  = gnt[1] ? m1_we : m0_we;

      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               owner_d = gnt[1];
               a_d     = gnt[1] ? m1_a : m0_a;
               d_d     = gnt[1] ? m1_d : m0_d;
               we_d    = pick_we;
               rd_d    = !pick_we;
               grant_d = gnt;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // ready may still be high from the previous access, so only irq is looked at here.
            if (irq) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ready) begin
               fin     = 1'b1;
               fin_spo = spo;
            end else if (cnt_q == CNT_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (fin) begin
         state_d = ST_DONE;
         grant_d = 2'b00;
         if (owner_q) begin
            m1_spo_d = fin_spo;
            m1_err_d = fin_err;
         end else begin
            m0_spo_d = fin_spo;
            m0_err_d = fin_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= MST_M0;
         last_q   <= MST_M1;
         a_q      <= 32'h0;
         d_q      <= 32'h0;
         we_q     <= 1'b0;
         rd_q     <= 1'b0;
         grant_q  <= 2'b00;
         cnt_q    <= '0;
         m0_spo_q <= 32'h0;
         m1_spo_q <= 32'h0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         a_q      <= a_d;
         d_q      <= d_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         m0_spo_q <= m0_spo_d;
         m1_spo_q <= m1_spo_d;
         m0_err_q <= m0_err_d;
         m1_err_q <= m1_err_d;
      end
   end

   assign a      = a_q;
   assign d      = d_q;
   assign we     = we_q;
   assign rd     = rd_q;
   assign grant  = grant_q;
   assign m0_ack = (state_q == ST_DONE) && (owner_q == MST_M0);
   assign m1_ack = (state_q == ST_DONE) && (owner_q == MST_M1);
   assign m0_spo = m0_spo_q;
   assign m1_spo = m1_spo_q;
   assign m0_err = m0_err_q;
   assign m1_err = m1_err_q;

endmodule

// File: tb/tb_mbus_arbiter.sv
// tb/tb_mbus_arbiter.sv - randomized self-checking bench for mbus_arbiter against a transaction-level model
module tb_mbus_arbiter;
   import pcpu_bus_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m0_ack, m0_err;
   logic [31:0] m0_a, m0_d, m0_spo;
   logic        m1_req, m1_we, m1_ack, m1_err;
   logic [31:0] m1_a, m1_d, m1_spo;
   logic [31:0] a, d, spo;
   logic        we, rd, ready, irq;
   logic [1:0]  grant;

   logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_we, f_rd;
   logic [31:0] f_m0_spo, f_m1_spo, f_a, f_d;
   logic [1:0]  f_grant;

   mbus_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_d(m0_d),
      .m0_spo(m0_spo), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_d(m1_d),
      .m1_spo(m1_spo), .m1_ack(m1_ack), .m1_err(m1_err),
      .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready), .irq(irq), .grant(grant)
   );

   mbus_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_d(m0_d),
      .m0_spo(f_m0_spo), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_d(m1_d),
      .m1_spo(f_m1_spo), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
      .a(f_a), .d(f_d), .we(f_we), .rd(f_rd), .spo(spo), .ready(ready), .irq(irq), .grant(f_grant)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit          pend [2];
   logic        mwe  [2];
   logic [31:0] ma   [2];
   logic [31:0] md   [2];
   logic [31:0] hspo [2];
   logic        herr [2];
   int          last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive_masters();
      m0_req = pend[0]; m0_we = mwe[0]; m0_a = ma[0]; m0_d = md[0];
      m1_req = pend[1]; m1_we = mwe[1]; m1_a = ma[1]; m1_d = md[1];
   endtask

   task automatic new_req(input int m);
      logic [3:0]  rg;
      logic [25:0] off;
      case ($urandom_range(0, 3))
         0:       rg = REG_DISTM;
         1:       rg = REG_MAINM;
         2:       rg = REG_MMIO;
         default: rg = REG_BOOTM;
      endcase
      off     = 26'($urandom);
      ma[m]   = {rg, off, 2'b00};
      md[m]   = $urandom;
      mwe[m]  = 1'($urandom_range(0, 1));
      pend[m] = 1'b1;
   endtask

   task automatic wait_strobe(input string tag);
      int n;
      n = 0;
      while (!(rd || we) && n < 8) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(rd | we), 32'd1);
   endtask

   task automatic wait_ack(input string tag);
      int n;
      n = 0;
      while (!(m0_ack || m1_ack) && n < TO + 10) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(m0_ack | m1_ack), 32'd1);
   endtask

   initial begin
      int owner, kind, lat, cyc, exp_cyc;
      logic [31:0] rdata, exp_spo;
      logic exp_err;

      rst = 1'b1; ready = 1'b0; irq = 1'b0; spo = 32'h0;
      for (int m = 0; m < 2; m++) begin
         pend[m] = 1'b0; mwe[m] = 1'b0; ma[m] = 32'h0; md[m] = 32'h0;
         hspo[m] = 32'h0; herr[m] = 1'b0;
      end
      last = 1;
      drive_masters();
      repeat (2) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_strobe", 32'(rd | we), 32'd0);
      check("rst_a", a, 32'h0);
      check("rst_ack", 32'(m0_ack | m1_ack), 32'd0);
      check("rst_spo", m0_spo | m1_spo, 32'h0);
      check("rst_err", 32'(m0_err | m1_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Both masters requesting continuously: alternation vs. fixed priority.
      new_req(0); new_req(1); ready = 1'b1;
      drive_masters();
      for (int k = 0; k < 4; k++) begin
         wait_strobe("rr_strobe");
         check("rr_grant", 32'(grant), (k % 2) ? 32'd2 : 32'd1);
         check("fix_grant", 32'(f_grant), 32'd1);
         check("fix_a", f_a, ma[0]);
         wait_ack("rr_ack");
         check("fix_ack", 32'(f_m0_ack), 32'd1);
      end
      pend[0] = 1'b0; pend[1] = 1'b0; ready = 1'b0;
      drive_masters();
      last = 1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 80; t++) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m] && $urandom_range(0, 2) != 0) new_req(m);
         if (!pend[0] && !pend[1]) new_req(0);
         drive_masters();
         owner = (pend[0] && pend[1]) ? ((last == 1) ? 0 : 1) : (pend[0] ? 0 : 1);

         wait_strobe("strobe");
         check("grant", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
         check("bus_a", a, ma[owner]);
         check("dir_we", 32'(we), 32'(mwe[owner]));
         check("dir_rd", 32'(rd), 32'(!mwe[owner]));
         if (mwe[owner]) check("bus_d", d, md[owner]);

         kind = $urandom_range(0, 9);
         if (kind == 1)      lat = TO + 4;
         else if (kind == 2) lat = TO - 1;
         else                lat = $urandom_range(0, 9);
         rdata = $urandom;
         irq   = (kind == 0);
         ready = 1'($urandom_range(0, 1));
         spo   = $urandom;

         @(negedge clk);
         cyc = 1;
         irq = 1'b0;
         check("strobe_1cyc", 32'(rd | we), 32'd0);
         check("a_hold", a, ma[owner]);
         while (!(m0_ack || m1_ack) && cyc < TO + 10) begin
            ready = (kind != 0) && (cyc - 1 == lat);
            spo   = ready ? rdata : $urandom;
            @(negedge clk);
            cyc++;
         end
         ready = 1'b0;

         exp_err = (kind == 0) || (lat >= TO);
         exp_spo = exp_err ? 32'h0 : rdata;
         exp_cyc = (kind == 0) ? 1 : ((lat >= TO) ? TO + 1 : lat + 2);
         check("ack_cycles", 32'(cyc), 32'(exp_cyc));
         check("ack_owner", 32'(owner ? m1_ack : m0_ack), 32'd1);
         check("ack_other", 32'(owner ? m0_ack : m1_ack), 32'd0);
         check("rsp_spo", owner ? m1_spo : m0_spo, exp_spo);
         check("rsp_err", 32'(owner ? m1_err : m0_err), 32'(exp_err));
         check("hold_spo", owner ? m0_spo : m1_spo, hspo[1 - owner]);
         check("hold_err", 32'(owner ? m0_err : m1_err), 32'(herr[1 - owner]));
         hspo[owner] = exp_spo;
         herr[owner] = exp_err;
         last = owner;

         if ($urandom_range(0, 1) != 0) new_req(owner);
         else pend[owner] = 1'b0;
         drive_masters();
         @(negedge clk);
         check("ack_pulse", 32'(m0_ack | m1_ack), 32'd0);
      end

      // Asynchronous reset in the middle of a WAIT.
      if (!pend[0]) new_req(0);
      if (!pend[1]) new_req(1);
      drive_masters();
      wait_strobe("rst_mid_strobe");
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_strobes", 32'(rd | we), 32'd0);
      check("rst_mid_grant", 32'(grant), 32'd0);
      check("rst_mid_ack", 32'(m0_ack | m1_ack), 32'd0);
      check("rst_mid_spo", m0_spo, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_strobe("post_rst_strobe");
      check("post_rst_grant", 32'(grant), 32'd1);
      check("post_rst_a", a, ma[0]);
      ready = 1'b1;
      wait_ack("post_rst_ack");
      check("post_rst_owner", 32'(m0_ack), 32'd1);
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive_masters();
      ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
